// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 window interface between window_stream_gen and conv_core.
package conv_pkg;
    localparam int PIX_W          = 8;
    localparam int COORD_X_W      = 11;
    localparam int COORD_Y_W      = 10;
    localparam int CONV_OUT_W     = 20;
    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;
endpackage

// File: rtl/line_buffer_ram.sv
// One image row of storage: a single shared address, combinational read of the
// pre-write contents, registered write.
module line_buffer_ram #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Read returns the value stored before this cycle's write lands.
    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
endmodule

// File: rtl/window_stream_gen.sv
// Raster pixel stream to 3x3 window stream: two line buffers feed a 3x3 shift
// register; a window is flagged once the accepted pixel has two rows and columns behind it.
module window_stream_gen #(
    parameter int IMG_WIDTH  = conv_pkg::DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = conv_pkg::DEF_IMG_HEIGHT,
    parameter int PIX_W      = conv_pkg::PIX_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PIX_W-1:0]              pix_in,
    input  logic                          pix_valid,
    input  logic                          sof,
    output logic [PIX_W-1:0]              w00,
    output logic [PIX_W-1:0]              w01,
    output logic [PIX_W-1:0]              w02,
    output logic [PIX_W-1:0]              w10,
    output logic [PIX_W-1:0]              w11,
    output logic [PIX_W-1:0]              w12,
    output logic [PIX_W-1:0]              w20,
    output logic [PIX_W-1:0]              w21,
    output logic [PIX_W-1:0]              w22,
    output logic                          window_valid,
    output logic                          fsm_window_valid,
    output logic [conv_pkg::COORD_X_W-1:0] x,
    output logic [conv_pkg::COORD_Y_W-1:0] y,
    output logic                          frame_done
);
    import conv_pkg::*;

    localparam int XW    = COORD_X_W;
    localparam int YW    = COORD_Y_W;
    localparam int LB_AW = $clog2(IMG_WIDTH);
    localparam logic [XW-1:0] COL_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(IMG_HEIGHT - 1);

    logic [XW-1:0] col, col_eff, col_nxt;
    logic [YW-1:0] row, row_eff, row_nxt;
    logic          col_last, row_last;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    logic [2:0][2:0][PIX_W-1:0] win;

    // sof rebases the current pixel to (0,0) before anything else looks at it.
    always_comb begin
        col_eff  = sof ? '0 : col;
        row_eff  = sof ? '0 : row;
        col_last = (col_eff == COL_LAST);
        row_last = (row_eff == ROW_LAST);
        col_nxt  = col;
        row_nxt  = row;
        if (pix_valid) begin
            col_nxt = col_last ? '0 : col_eff + XW'(1);
            if (col_last) row_nxt = row_last ? '0 : row_eff + YW'(1);
            else          row_nxt = row_eff;
        end else if (sof) begin
            col_nxt = '0;
            row_nxt = '0;
        end
    end

    // lb0 holds row-2, lb1 holds row-1; lb1's old entry ages into lb0.
    line_buffer_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb0 (
        .clk   (clk),
        .we    (pix_valid),
        .addr  (col_eff[LB_AW-1:0]),
        .wdata (lb1_rd),
        .rdata (lb0_rd)
    );

    line_buffer_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
        .clk   (clk),
        .we    (pix_valid),
        .addr  (col_eff[LB_AW-1:0]),
        .wdata (pix_in),
        .rdata (lb1_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            col          <= '0;
            row          <= '0;
            win          <= '0;
            x            <= '0;
            y            <= '0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            col          <= col_nxt;
            row          <= row_nxt;
            window_valid <= pix_valid && (row_eff >= YW'(2)) && (col_eff >= XW'(2));
            frame_done   <= pix_valid && col_last && row_last;
            if (pix_valid) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb0_rd;
                win[1][2] <= lb1_rd;
                win[2][2] <= pix_in;
                x         <= col_eff - XW'(1);
                y         <= row_eff - YW'(1);
            end
        end
    end

    assign fsm_window_valid = window_valid;

    assign w00 = win[0][0];
    assign w01 = win[0][1];
    assign w02 = win[0][2];
    assign w10 = win[1][0];
    assign w11 = win[1][1];
    assign w12 = win[1][2];
    assign w20 = win[2][0];
    assign w21 = win[2][1];
    assign w22 = win[2][2];
endmodule

// File: tb/tb_window_stream_gen.sv
// Directed bench for window_stream_gen on a 5x4 image: per-cycle compare against a
// frame-image model plus literal checks of key windows.
module tb_window_stream_gen;
    localparam int W = 5;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  pix_in = '0;
    logic        pix_valid = 1'b0;
    logic        sof = 1'b0;
    logic [7:0]  w00, w01, w02, w10, w11, w12, w20, w21, w22;
    logic        window_valid, fsm_window_valid, frame_done;
    logic [10:0] x;
    logic [9:0]  y;

    window_stream_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
        .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .w00(w00), .w01(w01), .w02(w02), .w10(w10), .w11(w11), .w12(w12),
        .w20(w20), .w21(w21), .w22(w22),
        .window_valid(window_valid), .fsm_window_valid(fsm_window_valid),
        .x(x), .y(y), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0][7:0] w;
        logic [10:0]     x;
        logic [9:0]      y;
        logic            done;
    } win_t;

    int n_chk = 0;
    int n_err = 0;

    // Model state: image of the frame so far, raster index of the next pixel.
    logic [7:0]      img [H][W];
    int              pidx = 0;
    logic            chk_en = 1'b0;
    logic            e_zero = 1'b0;
    logic            e_valid = 1'b0;
    logic            e_done = 1'b0;
    logic [8:0][7:0] e_win = '0;
    logic [10:0]     e_x = '0;
    logic [9:0]      e_y = '0;

    win_t wlog[$];
    win_t s1[$];

    wire [8:0][7:0] dw = {w22, w21, w20, w12, w11, w10, w02, w01, w00};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int k);
        return 8'((k / W) * 10 + (k % W));
    endfunction

    task automatic step(input bit v, input bit s, input logic [7:0] p);
        int r, c;
        pix_valid = v; sof = s; pix_in = p;
        @(posedge clk);
        e_zero = 1'b0;
        e_valid = 1'b0;
        e_done = 1'b0;
        if (s) pidx = 0;
        if (v) begin
            r = pidx / W;
            c = pidx % W;
            img[r][c] = p;
            if (r >= 2 && c >= 2) begin
                e_valid = 1'b1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e_win[i*3+j] = img[r-2+i][c-2+j];
                e_x = 11'(c - 1);
                e_y = 10'(r - 1);
            end
            e_done = (pidx == W*H - 1);
            pidx = (pidx + 1) % (W*H);
        end
        #1;
    endtask

    task automatic do_reset(input bit v, input logic [7:0] p);
        reset = 1'b1; pix_valid = v; pix_in = p; sof = 1'b0;
        @(posedge clk);
        pidx = 0;
        e_zero = 1'b1;
        e_valid = 1'b0;
        e_done = 1'b0;
        chk_en = 1'b1;
        #1;
        reset = 1'b0; pix_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (e_zero) begin
                chk("reset_outputs", {dw, x, y, window_valid, fsm_window_valid, frame_done}, '0);
            end else begin
                chk("window_valid", window_valid, e_valid);
                chk("fsm_window_valid", fsm_window_valid, e_valid);
                chk("frame_done", frame_done, e_done);
                if (e_valid) begin
                    chk("window", dw, e_win);
                    chk("x", x, e_x);
                    chk("y", y, e_y);
                end
            end
            if (window_valid) wlog.push_back('{w: dw, x: x, y: y, done: frame_done});
        end
    end

    initial begin
        int k, first, sum;
        logic [8:0][7:0] first_exp;
        first_exp = {8'd22, 8'd21, 8'd20, 8'd12, 8'd11, 8'd10, 8'd2, 8'd1, 8'd0};

        // Continuous frame
        do_reset(1'b0, 8'd0);
        wlog.delete();
        for (int i = 0; i < W*H; i++) step(1'b1, i == 0, pix(i));
        idle(2);
        chk("s1_count", wlog.size(), 6);
        if (wlog.size() == 6) begin
            chk("s1_first_win", wlog[0].w, first_exp);
            chk("s1_first_x", wlog[0].x, 1);
            chk("s1_first_y", wlog[0].y, 1);
            chk("s1_last_w00", wlog[5].w[0], 12);
            chk("s1_last_w22", wlog[5].w[8], 34);
            chk("s1_last_x", wlog[5].x, 3);
            chk("s1_last_y", wlog[5].y, 2);
            chk("s1_last_done", wlog[5].done, 1);
            sum = 0;
            for (int i = 0; i < 9; i++) sum += int'(wlog[5].w[i]);
            chk("s1_last_sum", sum, 207);
        end
        s1 = wlog;

        // Same frame with random stalls
        wlog.delete();
        k = 0;
        for (int it = 0; it < 400 && k < W*H; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                step(1'b1, k == 0, pix(k));
                k++;
            end else begin
                step(1'b0, 1'b0, 8'hee);
            end
        end
        chk("s2_all_accepted", k, W*H);
        idle(2);
        chk("s2_count", wlog.size(), s1.size());
        for (int i = 0; i < wlog.size() && i < s1.size(); i++)
            chk("s2_same_window", wlog[i], s1[i]);

        // Two back-to-back frames, second offset by 100
        wlog.delete();
        for (int i = 0; i < W*H; i++) step(1'b1, i == 0, pix(i));
        for (int i = 0; i < W*H; i++) step(1'b1, i == 0, pix(i) + 8'd100);
        idle(2);
        chk("s3_count", wlog.size(), 12);
        if (wlog.size() == 12) begin
            chk("s3_f2_w00", wlog[6].w[0], 100);
            chk("s3_f2_w22", wlog[6].w[8], 122);
            chk("s3_f2_x", wlog[6].x, 1);
            chk("s3_f2_y", wlog[6].y, 1);
        end

        // sof at (row 2, col 3) abandons frame 1
        wlog.delete();
        for (int i = 0; i < 13; i++) step(1'b1, i == 0, pix(i));
        first = -1;
        for (int i = 0; i < W*H; i++) begin
            step(1'b1, i == 0, pix(i) + 8'd50);
            if (window_valid && first < 0) first = i + 1;
        end
        idle(2);
        chk("s4_restart_len", first, 13);
        chk("s4_count", wlog.size(), 7);
        if (wlog.size() == 7) begin
            chk("s4_old_w22", wlog[0].w[8], 22);
            chk("s4_new_w22", wlog[1].w[8], 72);
            chk("s4_new_x", wlog[1].x, 1);
            chk("s4_new_y", wlog[1].y, 1);
        end

        // Reset in row 3, then a clean frame
        for (int i = 0; i < 16; i++) step(1'b1, i == 0, pix(i));
        do_reset(1'b1, 8'h77);
        chk("s5_rst_valid", window_valid, 0);
        chk("s5_rst_window", dw, 0);
        chk("s5_rst_xy", {x, y}, 0);
        wlog.delete();
        for (int i = 0; i < W*H; i++) step(1'b1, 1'b0, pix(i));
        idle(2);
        chk("s5_count", wlog.size(), 6);
        if (wlog.size() == 6) begin
            chk("s5_first_win", wlog[0].w, first_exp);
            chk("s5_last_done", wlog[5].done, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
